imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Shares the single asynchronous read port of the instruction memory between two requesters: the fetch stage and a data-side load port that reads constants/literal pools from program ROM. Fetch has fixed priority; a starvation counter guarantees the data port a grant after a bounded wait. Each accepted request returns a registered read word one cycle later. Sits between the core's fetch/LSU and the instruction memory.

## Interface
- ADDRESS_WIDTH, 32, width of all addresses
- DATA_WIDTH, 32, width of read data
- MAX_WAIT, 4, cycles the data port may be refused before it gets priority (≥1)

- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- f_req_i  in  1  fetch request; held with address stable until granted
- f_addr_i  in  ADDRESS_WIDTH  fetch byte address
- f_gnt_o  out  1  fetch request accepted this cycle
- f_rvalid_o  out  1  fetch response valid (one cycle)
- f_rdata_o  out  DATA_WIDTH  fetch response word
- d_req_i  in  1  data-port request; same hold rule
- d_addr_i  in  ADDRESS_WIDTH  data-port byte address
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data response valid (one cycle)
- d_rdata_o  out  DATA_WIDTH  data response word
- d_err_o  out  1  with d_rvalid_o: accepted address was misaligned (bits[1:0]≠0)
- mem_addr_o  out  ADDRESS_WIDTH  address to instruction memory
- mem_rdata_i  in  DATA_WIDTH  combinational read data from instruction memory

## Operation
- At most one grant per cycle; grants are combinational from requests and state.
- States S_FPRI (reset) and S_DPRI.
- S_FPRI: f_gnt_o = f_req_i; d_gnt_o = d_req_i & ~f_req_i.
- S_DPRI: d_gnt_o = d_req_i; f_gnt_o = f_req_i & ~d_req_i.
- wait_cnt (width clog2(MAX_WAIT+1)): +1 per cycle with d_req_i & ~d_gnt_o; cleared on d grant or d_req_i low.
- S_FPRI→S_DPRI on edge where d_req_i & ~d_gnt_o & wait_cnt == MAX_WAIT-1. S_DPRI→S_FPRI on edge where d_gnt_o or ~d_req_i.
- mem_addr_o = d_addr_i when d_gnt_o, else f_addr_i. Address bits[1:0] passed unchanged; memory ignores them.
- On a granted edge the winner's response register captures mem_rdata_i; its rvalid is high exactly the next cycle, otherwise low. rdata holds last value when rvalid low.
- d_err_o = registered (d_addr_i[1:0]≠0) of accepted data request, valid only with d_rvalid_o; rdata still returned. Fetch misalignment not flagged.
- Requester dropping req before grant: legal; no response, counter clears.

## Timing
- Reset (async assert, sync-released by clock domain): state S_FPRI, wait_cnt 0, f/d_rvalid_o 0, f/d_rdata_o 0, d_err_o 0. Gnt outputs follow reqs combinationally, including during reset deassertion cycle.
- Latency: grant at edge N → rvalid/rdata at cycle N+1. Back-to-back grants to the same port give rvalid every cycle.
- Both continuously requesting, MAX_WAIT=4: grants f,f,f,f,d repeating (d waits exactly MAX_WAIT cycles).
- Reset asserted mid-transaction: pending response dropped, no rvalid after release.
- Throughput: one access per cycle total.

## Structure
- Package imem_arb_pkg: state enum (S_FPRI, S_DPRI), requester id typedef (REQ_F, REQ_D).
- Sub-module imem_rsp_reg (capture-enable, rvalid/rdata/err flops), instantiated once per port.

## Test plan
- Reset with f_req_i=1, f_addr_i=0x10, mem word 0x00500093 → f_gnt_o=1 while held; after release, rvalid on cycle after first edge with f_rdata_o=0x00500093; all outputs 0 during reset.
- d only, d_addr_i=0x100 → d_gnt_o=1 same cycle, d_rvalid_o=1 next cycle with word at 0x100, d_err_o=0.
- Both requesting continuously 20 cycles, MAX_WAIT=4 → grant sequence f,f,f,f,d repeating; never simultaneous grants; each response on the correct port one cycle later.
- d_addr_i=0x102 → d_rvalid_o=1, d_err_o=1, data = word at 0x100.
- d waits 3 cycles then drops req; requests again → wait_cnt restarted, d granted only after 4 more refusals.
- rst_ni pulsed low the cycle after an f grant → f_rvalid_o stays 0, state returns S_FPRI.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
//   arb_state_e : arbitration priority state (S_FPRI at reset, S_DPRI)
//   req_id_e    : identifies the requester that owns the memory port
package imem_arb_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF    = 32;
  localparam int unsigned MAX_WAIT_DEF      = 4;

  typedef enum logic {
    S_FPRI = 1'b0,
    S_DPRI = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // Word-misaligned byte address (either of the two low bits set).
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Request/response and memory-side bundle of the instruction-memory arbiter.
//   slave  : arbiter view (takes requests and read data, drives grants/responses/address)
//   master : requester + memory view (the opposite directions)
interface imem_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);

  logic                     f_req_i;
  logic [ADDRESS_WIDTH-1:0] f_addr_i;
  logic                     f_gnt_o;
  logic                     f_rvalid_o;
  logic [DATA_WIDTH-1:0]    f_rdata_o;

  logic                     d_req_i;
  logic [ADDRESS_WIDTH-1:0] d_addr_i;
  logic                     d_gnt_o;
  logic                     d_rvalid_o;
  logic [DATA_WIDTH-1:0]    d_rdata_o;
  logic                     d_err_o;

  logic [ADDRESS_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]    mem_rdata_i;

  modport slave (
    input  f_req_i, f_addr_i, d_req_i, d_addr_i, mem_rdata_i,
    output f_gnt_o, f_rvalid_o, f_rdata_o,
           d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o, mem_addr_o
  );

  modport master (
    output f_req_i, f_addr_i, d_req_i, d_addr_i, mem_rdata_i,
    input  f_gnt_o, f_rvalid_o, f_rdata_o,
           d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o, mem_addr_o
  );

endinterface

// File: rtl/imem_rsp_reg.sv
// Per-port response register: captures read data on a granted edge and
// presents it with a one-cycle rvalid pulse.
//   clk_i, rst_ni : clock, async active-low reset
//   cap_i         : grant this cycle (capture enable)
//   data_i, err_i : memory read word and error flag to capture
//   rvalid_o      : high exactly the cycle after a capture
//   rdata_o       : captured word, held while rvalid_o is low
//   err_o         : captured error flag, only meaningful with rvalid_o
module imem_rsp_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cap_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  err_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= cap_i;
      err_o    <= cap_i & err_i;
      if (cap_i) begin
        rdata_o <= data_i;
      end
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single instruction-memory read port between fetch and the
// data-side load port. Fetch has priority until the data port has been refused
// MAX_WAIT cycles in a row, after which the data port wins one grant.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : fetch/data request-response channels and memory port
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned MAX_WAIT      = MAX_WAIT_DEF
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  imem_arbiter_if.slave  bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              f_gnt, d_gnt;
  req_id_e           owner;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic              f_err_unused;

  // State and starvation counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FPRI;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Grant decode, priority transitions and wait counting
  always_comb begin
    state_d = state_q;
    f_gnt   = 1'b0;
    d_gnt   = 1'b0;
    wait_d  = '0;
    case (state_q)
      S_FPRI: begin
        f_gnt = bus.f_req_i;
        d_gnt = bus.d_req_i & ~bus.f_req_i;
        if (bus.d_req_i && !d_gnt && wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = S_DPRI;
        end
      end
      S_DPRI: begin
        d_gnt = bus.d_req_i;
        f_gnt = bus.f_req_i & ~bus.d_req_i;
        if (d_gnt || !bus.d_req_i) begin
          state_d = S_FPRI;
        end
      end
      default: state_d = S_FPRI;
    endcase
    // Counts consecutive refusals; any grant or dropped request restarts it.
    if (bus.d_req_i && !d_gnt) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Memory address follows the current winner (fetch when idle)
  assign owner    = d_gnt ? REQ_D : REQ_F;
  assign mem_addr = (owner == REQ_D) ? bus.d_addr_i : bus.f_addr_i;

  assign bus.mem_addr_o = mem_addr;
  assign bus.f_gnt_o    = f_gnt;
  assign bus.d_gnt_o    = d_gnt;

  imem_rsp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_f_rsp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cap_i    (f_gnt),
    .data_i   (bus.mem_rdata_i),
    .err_i    (1'b0),
    .rvalid_o (bus.f_rvalid_o),
    .rdata_o  (bus.f_rdata_o),
    .err_o    (f_err_unused)
  );

  imem_rsp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_d_rsp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cap_i    (d_gnt),
    .data_i   (bus.mem_rdata_i),
    .err_i    (is_misaligned(bus.d_addr_i[1:0])),
    .rvalid_o (bus.d_rvalid_o),
    .rdata_o  (bus.d_rdata_o),
    .err_o    (bus.d_err_o)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a combinational ROM model.
module tb_imem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_ni;
  int   checks;
  int   failures;

  imem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  imem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word 0x10 holds an addi; other words are address-derived.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'h4) return 32'h0050_0093;
    return {a[31:2], 2'b00} ^ 32'hA5A5_0000;
  endfunction

  always_comb bus.mem_rdata_i = mem_word(bus.mem_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_d;
    checks   = 0;
    failures = 0;

    // Reset held with fetch requesting
    rst_ni       = 1'b0;
    bus.f_req_i  = 1'b1;
    bus.f_addr_i = 32'h10;
    bus.d_req_i  = 1'b0;
    bus.d_addr_i = 32'h0;
    #1;
    chk("rst_f_gnt", 32'(bus.f_gnt_o), 32'd1);
    chk("rst_d_gnt", 32'(bus.d_gnt_o), 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h10);
    chk("rst_f_rvalid", 32'(bus.f_rvalid_o), 32'd0);
    chk("rst_f_rdata", bus.f_rdata_o, 32'd0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid_o), 32'd0);
    chk("rst_d_rdata", bus.d_rdata_o, 32'd0);
    chk("rst_d_err", 32'(bus.d_err_o), 32'd0);
    tick();
    tick();
    chk("rst_hold_f_rvalid", 32'(bus.f_rvalid_o), 32'd0);
    chk("rst_hold_f_rdata", bus.f_rdata_o, 32'd0);

    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rel_f_gnt", 32'(bus.f_gnt_o), 32'd1);
    tick();
    chk("rel_f_rvalid", 32'(bus.f_rvalid_o), 32'd1);
    chk("rel_f_rdata", bus.f_rdata_o, 32'h0050_0093);
    chk("rel_d_rvalid", 32'(bus.d_rvalid_o), 32'd0);
    @(negedge clk);
    bus.f_req_i = 1'b0;
    tick();
    chk("idle_f_rvalid", 32'(bus.f_rvalid_o), 32'd0);
    chk("idle_f_rdata_hold", bus.f_rdata_o, 32'h0050_0093);

    // Data port alone, aligned
    @(negedge clk);
    bus.d_req_i  = 1'b1;
    bus.d_addr_i = 32'h100;
    #1;
    chk("d_only_d_gnt", 32'(bus.d_gnt_o), 32'd1);
    chk("d_only_f_gnt", 32'(bus.f_gnt_o), 32'd0);
    chk("d_only_mem_addr", bus.mem_addr_o, 32'h100);
    tick();
    chk("d_only_rvalid", 32'(bus.d_rvalid_o), 32'd1);
    chk("d_only_rdata", bus.d_rdata_o, mem_word(32'h100));
    chk("d_only_err", 32'(bus.d_err_o), 32'd0);
    chk("d_only_f_rvalid", 32'(bus.f_rvalid_o), 32'd0);

    // Data port misaligned: word still returned, error flagged
    @(negedge clk);
    bus.d_addr_i = 32'h102;
    #1;
    chk("mis_d_gnt", 32'(bus.d_gnt_o), 32'd1);
    tick();
    chk("mis_rvalid", 32'(bus.d_rvalid_o), 32'd1);
    chk("mis_err", 32'(bus.d_err_o), 32'd1);
    chk("mis_rdata", bus.d_rdata_o, mem_word(32'h100));
    @(negedge clk);
    bus.d_req_i = 1'b0;
    tick();
    chk("mis_after_rvalid", 32'(bus.d_rvalid_o), 32'd0);
    chk("mis_after_err", 32'(bus.d_err_o), 32'd0);

    // Both requesting: f,f,f,f,d repeating
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.f_req_i  = 1'b1;
      bus.f_addr_i = 32'h200;
      bus.d_req_i  = 1'b1;
      bus.d_addr_i = 32'h300;
      exp_d = ((i % 5) == 4);
      #1;
      chk($sformatf("both_f_gnt[%0d]", i), 32'(bus.f_gnt_o), 32'(!exp_d));
      chk($sformatf("both_d_gnt[%0d]", i), 32'(bus.d_gnt_o), 32'(exp_d));
      chk($sformatf("both_mem_addr[%0d]", i), bus.mem_addr_o, exp_d ? 32'h300 : 32'h200);
      tick();
      chk($sformatf("both_f_rvalid[%0d]", i), 32'(bus.f_rvalid_o), 32'(!exp_d));
      chk($sformatf("both_d_rvalid[%0d]", i), 32'(bus.d_rvalid_o), 32'(exp_d));
      if (exp_d) chk($sformatf("both_d_rdata[%0d]", i), bus.d_rdata_o, mem_word(32'h300));
      else       chk($sformatf("both_f_rdata[%0d]", i), bus.f_rdata_o, mem_word(32'h200));
    end
    @(negedge clk);
    bus.f_req_i = 1'b0;
    bus.d_req_i = 1'b0;
    tick();

    // Data refused 3 times, drops, re-requests: needs 4 fresh refusals
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.f_req_i = 1'b1;
      bus.d_req_i = 1'b1;
      #1;
      chk($sformatf("drop_pre_d_gnt[%0d]", i), 32'(bus.d_gnt_o), 32'd0);
      tick();
    end
    @(negedge clk);
    bus.d_req_i = 1'b0;
    #1;
    chk("drop_gap_d_gnt", 32'(bus.d_gnt_o), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.d_req_i = 1'b1;
      #1;
      chk($sformatf("drop_post_d_gnt[%0d]", i), 32'(bus.d_gnt_o), 32'(i == 4));
      chk($sformatf("drop_post_f_gnt[%0d]", i), 32'(bus.f_gnt_o), 32'(i != 4));
      tick();
    end
    @(negedge clk);
    bus.f_req_i = 1'b0;
    bus.d_req_i = 1'b0;
    tick();

    // Reset right after an f grant that also moved priority to the data port
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.f_req_i = 1'b1;
      bus.d_req_i = 1'b1;
      #1;
      chk($sformatf("pre_rst_f_gnt[%0d]", i), 32'(bus.f_gnt_o), 32'd1);
      tick();
    end
    chk("pre_rst_f_rvalid", 32'(bus.f_rvalid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_f_rvalid", 32'(bus.f_rvalid_o), 32'd0);
    chk("mid_rst_f_gnt", 32'(bus.f_gnt_o), 32'd1);
    chk("mid_rst_d_gnt", 32'(bus.d_gnt_o), 32'd0);
    @(negedge clk);
    bus.f_req_i = 1'b0;
    bus.d_req_i = 1'b0;
    tick();
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    chk("post_rst_f_rvalid", 32'(bus.f_rvalid_o), 32'd0);
    chk("post_rst_d_rvalid", 32'(bus.d_rvalid_o), 32'd0);
    @(negedge clk);
    bus.f_req_i = 1'b1;
    bus.d_req_i = 1'b1;
    #1;
    chk("post_rst_fpri_f_gnt", 32'(bus.f_gnt_o), 32'd1);
    chk("post_rst_fpri_d_gnt", 32'(bus.d_gnt_o), 32'd0);
    tick();
    @(negedge clk);
    bus.f_req_i = 1'b0;
    bus.d_req_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
